// File: rtl/forward_scoreboard_if.sv
// Bundles the EX-stage request fields and the bypass/stall results of the forwarding scoreboard.
// Latency: wires only, so it adds no cycles.
// Backpressure: none here. The stall is carried as a plain result signal.
// Ports:
//   master : the pipeline side. It drives the EX fields and reads the selects, stall and counter.
//   slave  : the scoreboard side.
interface forward_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
);
  logic                          hold_i;
  logic                          flush_i;
  logic                          ex_valid_i;
  logic                          ex_regwrite_i;
  logic                          ex_memread_i;
  logic [REG_ADDR_W-1:0]         ex_rd_i;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i;
  logic [NUM_SRC-1:0]            src_used_i;
  logic                          cnt_clr_i;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o;
  logic                          load_use_stall_o;
  logic [CNT_W-1:0]              stall_cnt_o;

  modport master (
    output hold_i, flush_i, ex_valid_i, ex_regwrite_i, ex_memread_i, ex_rd_i,
           src_addr_i, src_used_i, cnt_clr_i,
    input  fwd_sel_o, load_use_stall_o, stall_cnt_o
  );

  modport slave (
    input  hold_i, flush_i, ex_valid_i, ex_regwrite_i, ex_memread_i, ex_rd_i,
           src_addr_i, src_used_i, cnt_clr_i,
    output fwd_sel_o, load_use_stall_o, stall_cnt_o
  );
endinterface

// File: rtl/forward_scoreboard.sv
// Tracks in-flight register writers and produces per-operand ALU bypass selects and the load-use stall.
// Latency: the selects and the stall are combinational from the scoreboard state. The scoreboard advances one entry per edge.
// Backpressure: hold_i freezes all state. A load-use stall or a flush inserts a bubble into entry 0.
// Ports:
//   clk_i, rst_i : clock, and asynchronous active-low reset
//   bus          : slave modport carrying the EX fields, fwd_sel_o, load_use_stall_o and stall_cnt_o
module forward_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  forward_scoreboard_if.slave bus
);

  // Entry k: valid, is-load, destination. Entry 0 is the youngest producer (EX/MEM).
  logic [DEPTH-1:0]      v_q, v_d;
  logic [DEPTH-1:0]      ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_SRC-1:0]       hazard;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;

  // Youngest-match search per operand. The first hit ends the search.
  // A load that is not yet forwardable marks a hazard and leaves the select at 0.
  always_comb begin : match_search
    logic                  found;
    logic [REG_ADDR_W-1:0] addr;
    found   = 1'b0;
    addr    = '0;
    fwd_sel = '0;
    hazard  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      addr  = bus.src_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
      for (int k = 0; k < DEPTH; k++) begin
        // r0 writers stay in the scoreboard for ageing, but they never match.
        if (!found && bus.src_used_i[i] && v_q[k] && (rd_q[k] == addr) && (rd_q[k] != '0)) begin
          found = 1'b1;
          if (ld_q[k] && (k < LOAD_READY)) begin
            hazard[i] = 1'b1;
          end else begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  // A flushed or frozen EX instruction must not stall the pipe.
  assign stall = (|hazard) & ~bus.flush_i & ~bus.hold_i;

  always_comb begin
    v_d   = v_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // The clear also applies under hold. stall is already 0 under hold, so no increment happens then.
    if (bus.cnt_clr_i) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!bus.hold_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v_d[k]  = v_q[k-1];
        ld_d[k] = ld_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      v_d[0]  = bus.ex_valid_i & bus.ex_regwrite_i & ~bus.flush_i & ~stall;
      ld_d[0] = bus.ex_memread_i;
      rd_d[0] = bus.ex_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q   <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.fwd_sel_o        = fwd_sel;
  assign bus.load_use_stall_o = stall;
  assign bus.stall_cnt_o      = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard.
// Instance A uses the default parameters. Instance B uses CNT_W=2 and LOAD_READY=3, so a load stalls for several cycles in a row.
module tb_forward_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  forward_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .SEL_W(2), .CNT_W(16)) if_a ();
  forward_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .SEL_W(2), .CNT_W(2))  if_b ();

  forward_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(1), .SEL_W(2), .CNT_W(16))
    u_dut_a (.clk_i(clk), .rst_i(rst_n), .bus(if_a));
  forward_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(3), .SEL_W(2), .CNT_W(2))
    u_dut_b (.clk_i(clk), .rst_i(rst_n), .bus(if_b));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_a(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                      input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    if_a.ex_valid_i    = v;
    if_a.ex_regwrite_i = rw;
    if_a.ex_memread_i  = mr;
    if_a.ex_rd_i       = rd;
    if_a.src_addr_i    = {s1, s0};
    if_a.src_used_i    = used;
  endtask

  task automatic ex_b(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                      input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    if_b.ex_valid_i    = v;
    if_b.ex_regwrite_i = rw;
    if_b.ex_memread_i  = mr;
    if_b.ex_rd_i       = rd;
    if_b.src_addr_i    = {s1, s0};
    if_b.src_used_i    = used;
  endtask

  task automatic idle_a();
    ex_a(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    if_a.hold_i    = 1'b0;
    if_a.flush_i   = 1'b0;
    if_a.cnt_clr_i = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [1:0] sel_a(input int i);
    return if_a.fwd_sel_o[i*2 +: 2];
  endfunction

  task automatic test_reset();
    checks++; if (if_a.fwd_sel_o !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", if_a.fwd_sel_o); end
    checks++; if (if_a.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d exp 0", if_a.load_use_stall_o); end
    checks++; if (if_a.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", if_a.stall_cnt_o); end
    checks++; if (if_b.stall_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_cnt_b got %0d exp 0", if_b.stall_cnt_o); end
  endtask

  task automatic test_priority();
    idle_a();
    ex_a(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00);
    tick();
    tick();
    // Entries 0 and 1 both hold r5. Operand 1 also reads r5 but is marked unused.
    ex_a(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b01);
    #1;
    checks++; if (sel_a(0) !== 2'd1) begin errors++; $display("FAIL prio_op0 got %0d exp 1", sel_a(0)); end
    checks++; if (sel_a(1) !== 2'd0) begin errors++; $display("FAIL prio_unused_op1 got %0d exp 0", sel_a(1)); end
    checks++; if (if_a.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL prio_stall got %0d exp 0", if_a.load_use_stall_o); end
    if_a.src_used_i = 2'b11;
    #1;
    checks++; if (sel_a(1) !== 2'd1) begin errors++; $display("FAIL prio_op1_used got %0d exp 1", sel_a(1)); end
    tick();
    // The reader does not write, so entry 0 is now empty and the r5 writers sit in entries 1 and 2.
    checks++; if (if_a.fwd_sel_o !== {2'd2, 2'd2}) begin errors++; $display("FAIL prio_aged got %0h exp a", if_a.fwd_sel_o); end
  endtask

  task automatic test_load_use();
    idle_a();
    ex_a(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
    tick();
    ex_a(1'b1, 1'b1, 1'b0, 5'd9, 5'd7, 5'd0, 2'b01);
    #1;
    checks++; if (if_a.load_use_stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", if_a.load_use_stall_o); end
    checks++; if (sel_a(0) !== 2'd0) begin errors++; $display("FAIL lu_sel_forced got %0d exp 0", sel_a(0)); end
    checks++; if (if_a.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL lu_cnt_before got %0d exp 0", if_a.stall_cnt_o); end
    tick();
    checks++; if (if_a.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_release got %0d exp 0", if_a.load_use_stall_o); end
    checks++; if (sel_a(0) !== 2'd2) begin errors++; $display("FAIL lu_sel_memwb got %0d exp 2", sel_a(0)); end
    checks++; if (if_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", if_a.stall_cnt_o); end
    tick();
    // The r9 writer entered after the bubble. The load r7 is now in entry 2.
    ex_a(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd7, 2'b11);
    #1;
    checks++; if (if_a.fwd_sel_o !== {2'd3, 2'd1}) begin errors++; $display("FAIL lu_after got %0h exp d", if_a.fwd_sel_o); end
    checks++; if (if_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d exp 1", if_a.stall_cnt_o); end
  endtask

  task automatic test_r0_depth();
    idle_a();
    ex_a(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    tick();
    ex_a(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b01);
    #1;
    checks++; if (sel_a(0) !== 2'd0) begin errors++; $display("FAIL r0_sel got %0d exp 0", sel_a(0)); end
    tick();
    ex_a(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01);
    #1;
    checks++; if (sel_a(0) !== 2'd1) begin errors++; $display("FAIL depth_e0 got %0d exp 1", sel_a(0)); end
    tick();
    checks++; if (sel_a(0) !== 2'd2) begin errors++; $display("FAIL depth_e1 got %0d exp 2", sel_a(0)); end
    tick();
    checks++; if (sel_a(0) !== 2'd3) begin errors++; $display("FAIL depth_e2 got %0d exp 3", sel_a(0)); end
    tick();
    checks++; if (sel_a(0) !== 2'd0) begin errors++; $display("FAIL depth_out got %0d exp 0", sel_a(0)); end
  endtask

  task automatic test_flush_hold();
    idle_a();
    ex_a(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 2'b00);
    tick();
    ex_a(1'b1, 1'b1, 1'b0, 5'd6, 5'd4, 5'd0, 2'b01);
    if_a.flush_i = 1'b1;
    #1;
    checks++; if (if_a.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL flush_nostall got %0d exp 0", if_a.load_use_stall_o); end
    tick();
    if_a.flush_i = 1'b0;
    ex_a(1'b1, 1'b1, 1'b0, 5'd8, 5'd6, 5'd4, 2'b11);
    #1;
    // The flushed r6 write became a bubble. The load r4 is in entry 1.
    checks++; if (if_a.fwd_sel_o !== {2'd2, 2'd0}) begin errors++; $display("FAIL flush_bubble got %0h exp 8", if_a.fwd_sel_o); end
    checks++; if (if_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", if_a.stall_cnt_o); end
    if_a.hold_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if_a.flush_i = (c == 1);
      tick();
      checks++; if (if_a.fwd_sel_o !== {2'd2, 2'd0}) begin errors++; $display("FAIL hold_sel[%0d] got %0h exp 8", c, if_a.fwd_sel_o); end
      checks++; if (if_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp 1", c, if_a.stall_cnt_o); end
    end
    if_a.hold_i  = 1'b0;
    if_a.flush_i = 1'b0;
    tick();
    ex_a(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd4, 2'b11);
    #1;
    checks++; if (if_a.fwd_sel_o !== {2'd3, 2'd1}) begin errors++; $display("FAIL unhold_sel got %0h exp d", if_a.fwd_sel_o); end
  endtask

  task automatic test_counter();
    ex_b(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
    tick();
    ex_b(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01);
    #1;
    checks++; if (if_b.load_use_stall_o !== 1'b1) begin errors++; $display("FAIL cnt_stall0 got %0d exp 1", if_b.load_use_stall_o); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (if_b.stall_cnt_o !== 2'(c)) begin errors++; $display("FAIL cnt_step%0d got %0d exp %0d", c, if_b.stall_cnt_o, c); end
    end
    checks++; if (if_b.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL cnt_load_gone got %0d exp 0", if_b.load_use_stall_o); end
    ex_b(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
    tick();
    ex_b(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01);
    for (int c = 4; c <= 5; c++) begin
      tick();
      checks++; if (if_b.stall_cnt_o !== 2'd3) begin errors++; $display("FAIL cnt_sat%0d got %0d exp 3", c, if_b.stall_cnt_o); end
    end
    if_b.cnt_clr_i = 1'b1;
    #1;
    checks++; if (if_b.load_use_stall_o !== 1'b1) begin errors++; $display("FAIL cnt_clr_stall got %0d exp 1", if_b.load_use_stall_o); end
    tick();
    if_b.cnt_clr_i = 1'b0;
    checks++; if (if_b.stall_cnt_o !== 2'd0) begin errors++; $display("FAIL cnt_clr got %0d exp 0", if_b.stall_cnt_o); end
  endtask

  task automatic test_async_reset();
    idle_a();
    ex_a(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
    tick();
    ex_a(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01);
    #1;
    checks++; if (if_a.load_use_stall_o !== 1'b1) begin errors++; $display("FAIL arst_pre_stall got %0d exp 1", if_a.load_use_stall_o); end
    checks++; if (if_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL arst_pre_cnt got %0d exp 1", if_a.stall_cnt_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_a.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL arst_stall got %0d exp 0", if_a.load_use_stall_o); end
    checks++; if (if_a.fwd_sel_o !== 4'd0) begin errors++; $display("FAIL arst_sel got %0d exp 0", if_a.fwd_sel_o); end
    checks++; if (if_a.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", if_a.stall_cnt_o); end
    #2 rst_n = 1'b1;
    tick();
    // The load was invalidated, so the same reader no longer stalls.
    checks++; if (if_a.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL arst_post_stall got %0d exp 0", if_a.load_use_stall_o); end
  endtask

  initial begin
    ex_a(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    ex_b(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    if_a.hold_i = 1'b0; if_a.flush_i = 1'b0; if_a.cnt_clr_i = 1'b0;
    if_b.hold_i = 1'b0; if_b.flush_i = 1'b0; if_b.cnt_clr_i = 1'b0;
    #22 rst_n = 1'b1;
    tick();
    test_reset();
    test_priority();
    test_load_use();
    test_r0_depth();
    test_flush_hold();
    test_counter();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
